// File: rtl/cpu_control_unit.sv
// Multi-cycle control sequencer for the 8-bit ALU datapath: fetch/decode/execute,
// data-memory handshake, program counter and architectural flags.
module cpu_control_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [4:0]      alu_opcode,
  input  logic [2:0]      alu_flags,
  output logic            op2_sel,
  output logic [2:0]      rf_raddr1,
  output logic [2:0]      rf_raddr2,
  output logic            rf_we,
  output logic [2:0]      rf_waddr,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [7:0]      dmem_addr,
  input  logic            dmem_ack,
  output logic [2:0]      flags,
  output logic            halted
);

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_LOADC = 5'd3;
  localparam logic [4:0] OP_LOAD  = 5'd4;
  localparam logic [4:0] OP_STORE = 5'd5;
  localparam logic [4:0] OP_CMP   = 5'd6;
  localparam logic [4:0] OP_JMP   = 5'd7;
  localparam logic [4:0] OP_JZ    = 5'd8;
  localparam logic [4:0] OP_JC    = 5'd9;
  localparam logic [4:0] OP_HALT  = 5'd10;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALTED
  } state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt, pc_inc, target;
  logic [15:0]     ir, ir_nxt;
  logic [2:0]      flags_q, flags_nxt;
  logic [4:0]      op;

  // Codes beyond the ISA table run as NOP and present NOP to the ALU.
  function automatic logic op_known(input logic [4:0] o);
    return o <= OP_HALT;
  endfunction

  assign op        = ir[15:11];
  assign pc_inc    = pc + PC_W'(1);
  assign target    = PC_W'(ir[7:0]);
  assign imem_addr = pc;
  assign rf_raddr1 = ir[10:8];
  assign rf_raddr2 = ir[7:5];
  assign rf_waddr  = ir[10:8];
  assign dmem_addr = ir[7:0];
  assign flags     = flags_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      flags_q <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      ir      <= ir_nxt;
      flags_q <= flags_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ir_nxt     = ir;
    flags_nxt  = flags_q;
    imem_req   = 1'b0;
    alu_opcode = OP_NOP;
    op2_sel    = 1'b0;
    rf_we      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_nxt    = imem_data;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: state_nxt = S_EXECUTE;
      S_EXECUTE: begin
        state_nxt = S_FETCH;
        pc_nxt    = pc_inc;
        if (op_known(op)) alu_opcode = op;
        case (op)
          OP_ADD, OP_SUB: rf_we = 1'b1;
          OP_LOADC: begin
            op2_sel = 1'b1;
            rf_we   = 1'b1;
          end
          OP_CMP: flags_nxt = alu_flags;
          OP_LOAD, OP_STORE: begin
            pc_nxt    = pc;
            state_nxt = S_MEM;
          end
          OP_JMP: pc_nxt = target;
          OP_JZ:  if (flags_q[0]) pc_nxt = target;
          OP_JC:  if (flags_q[1]) pc_nxt = target;
          OP_HALT: begin
            pc_nxt    = pc;
            state_nxt = S_HALTED;
          end
          default: ;
        endcase
      end
      // PC advances past a store only once memory has acknowledged it.
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OP_STORE);
        if (dmem_ack) begin
          if (op == OP_STORE) begin
            pc_nxt    = pc_inc;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        alu_opcode = OP_LOAD;
        op2_sel    = 1'b1;
        rf_we      = 1'b1;
        pc_nxt     = pc_inc;
        state_nxt  = S_FETCH;
      end
      S_HALTED: halted = 1'b1;
      default:  state_nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: fetch timing, ALU/branch/memory sequencing,
// flag capture, PC wrap, halt and reset.
module tb_cpu_control_unit;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_LOADC = 5'd3;
  localparam logic [4:0] OP_LOAD  = 5'd4;
  localparam logic [4:0] OP_STORE = 5'd5;
  localparam logic [4:0] OP_CMP   = 5'd6;
  localparam logic [4:0] OP_JMP   = 5'd7;
  localparam logic [4:0] OP_JZ    = 5'd8;
  localparam logic [4:0] OP_JC    = 5'd9;
  localparam logic [4:0] OP_HALT  = 5'd10;

  logic        clk, rst;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [4:0]  alu_opcode;
  logic [2:0]  alu_flags;
  logic        op2_sel, rf_we, dmem_req, dmem_we, dmem_ack, halted;
  logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr, flags;
  logic [7:0]  dmem_addr;

  int passed = 0;
  int total  = 0;

  cpu_control_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .alu_opcode(alu_opcode), .alu_flags(alu_flags), .op2_sel(op2_sel),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack),
    .flags(flags), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] enc(input logic [4:0] o, input logic [2:0] rd, input logic [7:0] imm);
    return {o, rd, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction for one cycle while the DUT is fetching.
  task automatic give_insn(input logic [15:0] insn);
    imem_ack  = 1'b1;
    imem_data = insn;
    tick();
    imem_ack  = 1'b0;
    imem_data = 16'h0;
  endtask

  task automatic run3(input logic [15:0] insn);
    give_insn(insn);
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (imem_req !== 1'b1) $display("FAIL rst_imem_req got %b exp 1", imem_req); else passed++;
    total++; if (imem_addr !== 8'h00) $display("FAIL rst_imem_addr got %h exp 00", imem_addr); else passed++;
    total++; if (flags !== 3'b000) $display("FAIL rst_flags got %b exp 000", flags); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL rst_halted got %b exp 0", halted); else passed++;
    total++; if ({rf_we, dmem_req} !== 2'b00) $display("FAIL rst_enables got %b exp 00", {rf_we, dmem_req}); else passed++;
    total++; if (alu_opcode !== OP_NOP) $display("FAIL rst_aluop got %0d exp 0", alu_opcode); else passed++;
    // Reset in the middle of an instruction, then held two cycles with an offered ack.
    give_insn(enc(OP_LOADC, 3'd1, 8'd5));
    tick();
    rst = 1'b1;
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) $display("FAIL rst_mid got req=%b addr=%h exp 1/00", imem_req, imem_addr); else passed++;
    total++; if (rf_we !== 1'b0) $display("FAIL rst_mid_we got %b exp 0", rf_we); else passed++;
    imem_ack  = 1'b1;
    imem_data = enc(OP_HALT, 3'd0, 8'd0);
    tick();
    imem_ack  = 1'b0;
    imem_data = 16'h0;
    tick();
    rst = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) $display("FAIL rst_hold got req=%b addr=%h exp 1/00", imem_req, imem_addr); else passed++;
  endtask

  task automatic test_alu_seq();
    logic [15:0] prog [3];
    logic [4:0]  eop  [3];
    logic        esel [3];
    prog[0] = enc(OP_LOADC, 3'd1, 8'd5);        eop[0] = OP_LOADC; esel[0] = 1'b1;
    prog[1] = enc(OP_LOADC, 3'd2, 8'd3);        eop[1] = OP_LOADC; esel[1] = 1'b1;
    prog[2] = enc(OP_ADD,   3'd1, {3'd2, 5'd0}); eop[2] = OP_ADD;   esel[2] = 1'b0;
    alu_flags = 3'b110;
    for (int i = 0; i < 3; i++) begin
      total++; if (imem_req !== 1'b1 || imem_addr !== 8'(i)) $display("FAIL alu_fetch%0d got req=%b addr=%h exp 1/%h", i, imem_req, imem_addr, 8'(i)); else passed++;
      give_insn(prog[i]);
      total++; if (imem_req !== 1'b0 || rf_we !== 1'b0 || alu_opcode !== OP_NOP) $display("FAIL alu_decode%0d got req=%b we=%b op=%0d exp 0/0/0", i, imem_req, rf_we, alu_opcode); else passed++;
      total++; if (rf_raddr1 !== prog[i][10:8] || rf_raddr2 !== prog[i][7:5]) $display("FAIL alu_raddr%0d got %0d,%0d exp %0d,%0d", i, rf_raddr1, rf_raddr2, prog[i][10:8], prog[i][7:5]); else passed++;
      tick();
      total++; if (alu_opcode !== eop[i] || rf_we !== 1'b1 || rf_waddr !== prog[i][10:8] || op2_sel !== esel[i]) $display("FAIL alu_exec%0d got op=%0d we=%b wa=%0d sel=%b exp %0d/1/%0d/%b", i, alu_opcode, rf_we, rf_waddr, op2_sel, eop[i], prog[i][10:8], esel[i]); else passed++;
      tick();
      total++; if (rf_we !== 1'b0 || alu_opcode !== OP_NOP) $display("FAIL alu_after%0d got we=%b op=%0d exp 0/0", i, rf_we, alu_opcode); else passed++;
    end
    total++; if (imem_addr !== 8'h03) $display("FAIL alu_pc got %h exp 03", imem_addr); else passed++;
    total++; if (flags !== 3'b000) $display("FAIL alu_flags_kept got %b exp 000", flags); else passed++;
  endtask

  task automatic test_cmp_taken();
    alu_flags = 3'b001;
    give_insn(enc(OP_CMP, 3'd1, {3'd2, 5'd0}));
    tick();
    total++; if (alu_opcode !== OP_CMP || rf_we !== 1'b0) $display("FAIL cmp_exec got op=%0d we=%b exp 6/0", alu_opcode, rf_we); else passed++;
    tick();
    alu_flags = 3'b110;
    total++; if (flags !== 3'b001) $display("FAIL cmp_eq_flags got %b exp 001", flags); else passed++;
    run3(enc(OP_ADD, 3'd1, {3'd2, 5'd0}));
    total++; if (flags !== 3'b001) $display("FAIL add_keeps_flags got %b exp 001", flags); else passed++;
    total++; if (imem_addr !== 8'h05) $display("FAIL pre_jz_pc got %h exp 05", imem_addr); else passed++;
    run3(enc(OP_JZ, 3'd0, 8'h40));
    total++; if (imem_addr !== 8'h40) $display("FAIL jz_taken got %h exp 40", imem_addr); else passed++;
  endtask

  task automatic test_cmp_not_taken();
    alu_flags = 3'b110;
    run3(enc(OP_CMP, 3'd1, {3'd2, 5'd0}));
    alu_flags = 3'b001;
    total++; if (flags !== 3'b110) $display("FAIL cmp_lt_flags got %b exp 110", flags); else passed++;
    run3(enc(OP_JZ, 3'd0, 8'h40));
    total++; if (imem_addr !== 8'h42) $display("FAIL jz_not_taken got %h exp 42", imem_addr); else passed++;
    run3(enc(OP_JC, 3'd0, 8'h80));
    total++; if (imem_addr !== 8'h80) $display("FAIL jc_taken got %h exp 80", imem_addr); else passed++;
  endtask

  task automatic test_load();
    give_insn(enc(OP_LOAD, 3'd3, 8'h10));
    tick();
    total++; if (dmem_req !== 1'b0) $display("FAIL load_exec_req got %b exp 0", dmem_req); else passed++;
    tick();
    for (int k = 0; k < 4; k++) begin
      total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 8'h10 || rf_we !== 1'b0) $display("FAIL load_mem%0d got req=%b we=%b addr=%h rfwe=%b exp 1/0/10/0", k, dmem_req, dmem_we, dmem_addr, rf_we); else passed++;
      imem_ack  = (k == 0);
      imem_data = enc(OP_HALT, 3'd7, 8'hEE);
      dmem_ack  = (k == 3);
      tick();
    end
    imem_ack  = 1'b0;
    imem_data = 16'h0;
    dmem_ack  = 1'b0;
    total++; if (dmem_req !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 3'd3 || alu_opcode !== OP_LOAD || op2_sel !== 1'b1) $display("FAIL load_wb got req=%b we=%b wa=%0d op=%0d sel=%b exp 0/1/3/4/1", dmem_req, rf_we, rf_waddr, alu_opcode, op2_sel); else passed++;
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h81 || rf_we !== 1'b0) $display("FAIL load_next got req=%b addr=%h we=%b exp 1/81/0", imem_req, imem_addr, rf_we); else passed++;
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    total++; if (imem_req !== 1'b1 || dmem_req !== 1'b0 || imem_addr !== 8'h81) $display("FAIL fetch_dack_ignored got ireq=%b dreq=%b addr=%h exp 1/0/81", imem_req, dmem_req, imem_addr); else passed++;
  endtask

  task automatic test_store();
    give_insn(enc(OP_STORE, 3'd4, 8'h22));
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 8'h22 || rf_we !== 1'b0) $display("FAIL store_mem%0d got req=%b we=%b addr=%h rfwe=%b exp 1/1/22/0", k, dmem_req, dmem_we, dmem_addr, rf_we); else passed++;
      dmem_ack = (k == 3);
      tick();
    end
    dmem_ack = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h82 || rf_we !== 1'b0 || dmem_req !== 1'b0) $display("FAIL store_next got req=%b addr=%h we=%b dreq=%b exp 1/82/0/0", imem_req, imem_addr, rf_we, dmem_req); else passed++;
  endtask

  task automatic test_wrap_halt();
    run3(enc(OP_JMP, 3'd0, 8'hFF));
    total++; if (imem_addr !== 8'hFF) $display("FAIL jmp_ff got %h exp ff", imem_addr); else passed++;
    run3(enc(OP_NOP, 3'd0, 8'h00));
    total++; if (imem_addr !== 8'h00) $display("FAIL pc_wrap got %h exp 00", imem_addr); else passed++;
    give_insn(enc(5'h1F, 3'd5, 8'hA0));
    tick();
    total++; if (alu_opcode !== OP_NOP || rf_we !== 1'b0 || dmem_req !== 1'b0) $display("FAIL undef_exec got op=%0d we=%b dreq=%b exp 0/0/0", alu_opcode, rf_we, dmem_req); else passed++;
    tick();
    total++; if (imem_addr !== 8'h01) $display("FAIL undef_pc got %h exp 01", imem_addr); else passed++;
    run3(enc(OP_HALT, 3'd0, 8'h00));
    for (int k = 0; k < 20; k++) begin
      total++; if (halted !== 1'b1 || imem_req !== 1'b0 || dmem_req !== 1'b0) $display("FAIL halt%0d got halted=%b ireq=%b dreq=%b exp 1/0/0", k, halted, imem_req, dmem_req); else passed++;
      imem_ack = k[0];
      dmem_ack = k[1];
      tick();
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h00 || flags !== 3'b000) $display("FAIL halt_rst got halted=%b req=%b addr=%h flags=%b exp 0/1/00/000", halted, imem_req, imem_addr, flags); else passed++;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_data = 16'h0; dmem_ack = 1'b0; alu_flags = 3'b000;
    test_reset();
    test_alu_seq();
    test_cmp_taken();
    test_cmp_not_taken();
    test_load();
    test_store();
    test_wrap_halt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
